// File: rtl/mac_pkg.sv
// Shared MAC definitions: controller state encoding and default datapath sizes.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

    localparam int MAC_W       = 8;
    localparam int MAC_FRAC    = 4;
    localparam int MAC_MAX_LEN = 16;

endpackage

// File: rtl/mac_sat.sv
// Fixed-point rescale of the accumulator (floor shift by FRAC) and
// saturation to a W-bit signed result.
module mac_sat
    import mac_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int W     = MAC_W,
    parameter int FRAC  = MAC_FRAC
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [W-1:0]     res_o,
    output logic             ovf_o
);

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [ACC_W-1:0] shr;

    always_comb begin
        shr   = $signed(acc_i) >>> FRAC;
        res_o = shr[W-1:0];
        ovf_o = 1'b0;
        if (shr > MAXV) begin
            res_o = {1'b0, {(W-1){1'b1}}};
            ovf_o = 1'b1;
        end else if (shr < MINV) begin
            res_o = {1'b1, {(W-1){1'b0}}};
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/param_mac.sv
// Streaming signed fixed-point dot-product unit: multiply, accumulate,
// then rescale and saturate once the last term has drained.
module param_mac
    import mac_pkg::*;
#(
    parameter int  W       = MAC_W,
    parameter int  FRAC    = MAC_FRAC,
    parameter int  MAX_LEN = MAC_MAX_LEN,
    parameter int  ACC_W   = 2 * W + $clog2(MAX_LEN),
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stMAC,
    input  logic [LEN_W-1:0] len,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     result,
    output logic             done,
    output logic             ovf,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    mac_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             drain_q, drain_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic             prod_v_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [W-1:0]     res_q, res_d, sat_res;
    logic             ovf_q, ovf_d, sat_ovf;
    logic             start, accept;

    assign start    = (state_q == IDLE) && stMAC;
    assign in_ready = (state_q == RUN) && (rem_q != '0);
    assign accept   = in_ready && in_valid;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign result   = res_q;
    assign ovf      = ovf_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (stMAC) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        rem_d   = (len > LEN_MAX) ? LEN_MAX : len;
                    end
                end
            end
            RUN: begin
                if (accept) rem_d = rem_q - 1'b1;
                if (rem_q == '0) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands sign-extended to 2W so the truncated product is the exact signed product.
    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        if (accept) prod_d = {{W{b[W-1]}}, b} * {{W{c[W-1]}}, c};
        if (start) begin
            acc_d = '0;
        end else if (prod_v_q) begin
            acc_d = acc_q + {{(ACC_W-2*W){prod_q[2*W-1]}}, prod_q};
        end
        if (start && (len == '0)) begin
            res_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == DRAIN) && drain_q) begin
            res_d = sat_res;
            ovf_d = sat_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            drain_q  <= 1'b0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            drain_q  <= drain_d;
            prod_q   <= prod_d;
            prod_v_q <= accept;
            acc_q    <= acc_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
        end
    end

    mac_sat #(
        .ACC_W (ACC_W),
        .W     (W),
        .FRAC  (FRAC)
    ) u_sat (
        .acc_i (acc_q),
        .res_o (sat_res),
        .ovf_o (sat_ovf)
    );

endmodule

// File: tb/tb_param_mac.sv
// Bench for param_mac: dot-product model with timing expectations,
// per-cycle output compare and directed literal checks.
module tb_param_mac;

    localparam int W       = 8;
    localparam int FRAC    = 4;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stMAC = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [W-1:0]     b = '0;
    logic [W-1:0]     c = '0;
    logic             in_valid = 1'b0;
    logic             in_ready, done, ovf, busy;
    logic [W-1:0]     result;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    logic       exp_busy  = 1'b0;
    logic       exp_ready = 1'b0;
    int         exp_done_cyc = -1;
    logic [W-1:0] cur_res  = '0;
    logic [W-1:0] pend_res = '0;
    logic       cur_ovf  = 1'b0;
    logic       pend_ovf = 1'b0;

    logic [W-1:0] tb_b [32];
    logic [W-1:0] tb_c [32];

    param_mac dut (
        .clk      (clk),
        .rst      (rst),
        .stMAC    (stMAC),
        .len      (len),
        .b        (b),
        .c        (c),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .done     (done),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected dot product: exact integer sum, floor rescale, clamp.
    function automatic void model_dot(input int n, output logic [W-1:0] r, output logic o);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++)
            s += longint'($signed(tb_b[i])) * longint'($signed(tb_c[i]));
        s = s >>> FRAC;
        o = 1'b1;
        if (s > 127) r = 8'h7F;
        else if (s < -128) r = 8'h80;
        else begin
            r = s[7:0];
            o = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        logic dn;
        dn = (cyc == exp_done_cyc);
        if (dn) begin
            cur_res = pend_res;
            cur_ovf = pend_ovf;
        end
        chk("done", 32'(done), 32'(dn));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("result", 32'(result), 32'(cur_res));
        chk("ovf", 32'(ovf), 32'(cur_ovf));
        if (dn) begin
            exp_busy     = 1'b0;
            exp_done_cyc = -1;
        end
    end

    task automatic st(input int i, input logic [7:0] bb, input logic [7:0] cc);
        tb_b[i] = bb;
        tb_c[i] = cc;
    endtask

    task automatic run_op(input int lenv, input int gap_mask, input bit poke, input bit rel_rst);
        int n, i, t;
        n = (lenv > MAX_LEN) ? MAX_LEN : lenv;
        @(negedge clk);
        if (rel_rst) rst = 1'b0;
        stMAC = 1'b1;
        len   = LEN_W'(lenv);
        @(posedge clk);
        #1;
        stMAC    = 1'b0;
        exp_busy = 1'b1;
        if (n == 0) begin
            pend_res     = '0;
            pend_ovf     = 1'b0;
            exp_done_cyc = cyc;
        end else begin
            exp_ready = 1'b1;
            i = 0;
            t = 0;
            while (i < n) begin
                @(negedge clk);
                stMAC = poke;
                len   = '0;
                if (gap_mask[t % 32]) begin
                    in_valid = 1'b0;
                    b = 8'h55;
                    c = 8'h55;
                end else begin
                    in_valid = 1'b1;
                    b = tb_b[i];
                    c = tb_c[i];
                end
                @(posedge clk);
                #1;
                if (in_valid) i++;
                t++;
            end
            in_valid  = 1'b0;
            stMAC     = 1'b0;
            exp_ready = 1'b0;
            model_dot(n, pend_res, pend_ovf);
            exp_done_cyc = cyc + 3;
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);

        st(0, 8'h18, 8'h20);
        run_op(1, 0, 1'b0, 1'b1);
        chk("lit_single", 32'(result), 32'h30);
        chk("lit_single_ovf", 32'(ovf), 32'h0);

        st(0, 8'h18, 8'h20);
        st(1, 8'h10, 8'hF0);
        run_op(2, 32'h2, 1'b1, 1'b0);
        chk("lit_two", 32'(result), 32'h20);
        chk("lit_two_ovf", 32'(ovf), 32'h0);

        st(0, 8'h7F, 8'h7F);
        run_op(1, 0, 1'b0, 1'b0);
        chk("lit_possat", 32'(result), 32'h7F);
        chk("lit_possat_ovf", 32'(ovf), 32'h1);

        st(0, 8'h7F, 8'h80);
        run_op(1, 0, 1'b0, 1'b0);
        chk("lit_negsat", 32'(result), 32'h80);
        chk("lit_negsat_ovf", 32'(ovf), 32'h1);

        // Abort a 4-term run after two accepted terms.
        st(0, 8'h20, 8'h20);
        st(1, 8'h20, 8'h20);
        @(negedge clk);
        stMAC = 1'b1;
        len   = 5'd4;
        @(posedge clk);
        #1;
        stMAC     = 1'b0;
        exp_busy  = 1'b1;
        exp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            b = tb_b[k];
            c = tb_c[k];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst          = 1'b1;
        exp_busy     = 1'b0;
        exp_ready    = 1'b0;
        exp_done_cyc = -1;
        cur_res      = '0;
        cur_ovf      = 1'b0;
        #1;
        chk("midrst_result", 32'(result), 32'h0);
        chk("midrst_ovf", 32'(ovf), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'h0);
        repeat (2) @(negedge clk);
        st(0, 8'h10, 8'h10);
        run_op(1, 0, 1'b0, 1'b1);
        chk("lit_after_rst", 32'(result), 32'h10);

        // Zero-length run, then a start request while still in DONE.
        run_op(0, 0, 1'b0, 1'b0);
        @(negedge clk);
        stMAC = 1'b1;
        len   = 5'd3;
        @(posedge clk);
        #1;
        stMAC = 1'b0;
        len   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_len0", 32'(result), 32'h0);
        chk("lit_len0_ovf", 32'(ovf), 32'h0);

        st(0, 8'h08, 8'h10);
        st(1, 8'hF8, 8'h04);
        st(2, 8'h30, 8'h10);
        st(3, 8'h01, 8'h01);
        st(4, 8'hFF, 8'hFF);
        run_op(5, 32'h4A, 1'b0, 1'b0);
        chk("lit_mixed", 32'(result), 32'h36);

        st(0, 8'hFF, 8'h01);
        run_op(1, 0, 1'b0, 1'b0);
        chk("lit_floor", 32'(result), 32'hFF);
        chk("lit_floor_ovf", 32'(ovf), 32'h0);

        for (int k = 0; k < 20; k++) st(k, 8'h10, 8'h04);
        run_op(20, 0, 1'b0, 1'b0);
        chk("lit_clamp", 32'(result), 32'h40);

        for (int k = 0; k < 16; k++) st(k, 8'h80, 8'h80);
        run_op(16, 32'h100, 1'b0, 1'b0);
        chk("lit_nowrap", 32'(result), 32'h7F);
        chk("lit_nowrap_ovf", 32'(ovf), 32'h1);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
